// File: rtl/chronologic.sv
// rtl/chronologic.sv - toggle/liveness monitor with pass/fail strobes, counters and first-fail capture
module chronologic #(
    parameter int WIDTH    = 1,
    parameter int CNT_W    = 16,
    parameter int MAX_IDLE = 0,
    parameter bit PREV_RST = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic [WIDTH-1:0] a,
    output logic             toggled,
    output logic             pass,
    output logic             fail,
    output logic             err_sticky,
    output logic [CNT_W-1:0] pass_cnt,
    output logic [CNT_W-1:0] fail_cnt,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] idle_cnt,
    output logic [CNT_W-1:0] first_fail_cyc
);

    // One extra bit so the idle-window limit compares without truncation at the top of the range.
    localparam logic [CNT_W:0] MAX_IDLE_W = (CNT_W+1)'(MAX_IDLE);

    logic [WIDTH-1:0] prev_q;
    logic             toggled_q, toggled_d;
    logic             pass_q, pass_d;
    logic             fail_q, fail_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] pass_cnt_q, pass_cnt_d;
    logic [CNT_W-1:0] fail_cnt_q, fail_cnt_d;
    logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;
    logic [CNT_W-1:0] idle_cnt_q, idle_cnt_d;
    logic [CNT_W-1:0] first_fail_q, first_fail_d;

    logic             chg;
    logic             check;
    logic [CNT_W-1:0] cycle_nxt;
    logic [CNT_W-1:0] idle_nxt;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    assign chg       = (a != prev_q);
    assign check     = en && !clr;
    assign cycle_nxt = sat_inc(cycle_cnt_q);
    assign idle_nxt  = sat_inc(idle_cnt_q);

    always_comb begin
        toggled_d    = 1'b0;
        pass_d       = 1'b0;
        fail_d       = 1'b0;
        err_d        = err_q;
        pass_cnt_d   = pass_cnt_q;
        fail_cnt_d   = fail_cnt_q;
        cycle_cnt_d  = cycle_cnt_q;
        idle_cnt_d   = idle_cnt_q;
        first_fail_d = first_fail_q;

        if (clr) begin
            err_d        = 1'b0;
            pass_cnt_d   = '0;
            fail_cnt_d   = '0;
            cycle_cnt_d  = '0;
            idle_cnt_d   = '0;
            first_fail_d = '0;
        end else if (check) begin
            toggled_d   = chg;
            cycle_cnt_d = cycle_nxt;
            if (chg) begin
                idle_cnt_d = '0;
                pass_d     = 1'b1;
                pass_cnt_d = sat_inc(pass_cnt_q);
            end else begin
                idle_cnt_d = idle_nxt;
                if ({1'b0, idle_nxt} > MAX_IDLE_W) begin
                    fail_d     = 1'b1;
                    fail_cnt_d = sat_inc(fail_cnt_q);
                    err_d      = 1'b1;
                    if (!err_q) begin
                        first_fail_d = cycle_nxt;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_q       <= {WIDTH{PREV_RST}};
            toggled_q    <= 1'b0;
            pass_q       <= 1'b0;
            fail_q       <= 1'b0;
            err_q        <= 1'b0;
            pass_cnt_q   <= '0;
            fail_cnt_q   <= '0;
            cycle_cnt_q  <= '0;
            idle_cnt_q   <= '0;
            first_fail_q <= '0;
        end else begin
            prev_q       <= a;
            toggled_q    <= toggled_d;
            pass_q       <= pass_d;
            fail_q       <= fail_d;
            err_q        <= err_d;
            pass_cnt_q   <= pass_cnt_d;
            fail_cnt_q   <= fail_cnt_d;
            cycle_cnt_q  <= cycle_cnt_d;
            idle_cnt_q   <= idle_cnt_d;
            first_fail_q <= first_fail_d;
        end
    end

    assign toggled        = toggled_q;
    assign pass           = pass_q;
    assign fail           = fail_q;
    assign err_sticky     = err_q;
    assign pass_cnt       = pass_cnt_q;
    assign fail_cnt       = fail_cnt_q;
    assign cycle_cnt      = cycle_cnt_q;
    assign idle_cnt       = idle_cnt_q;
    assign first_fail_cyc = first_fail_q;

endmodule

// File: tb/tb_chronologic.sv
// tb/tb_chronologic.sv - directed vector bench for chronologic
module tb_chronologic;

    logic clk, rst;

    // u0: defaults; u1: MAX_IDLE=2; u2: CNT_W=3; u3: WIDTH=4
    logic       en0, clr0, a0;
    logic       tog0, p0, f0, e0;
    logic [15:0] pc0, fc0, cc0, ic0, ff0;

    logic       en1, a1;
    logic       tog1, p1, f1, e1;
    logic [15:0] pc1, fc1, cc1, ic1, ff1;

    logic       en2, a2;
    logic       tog2, p2, f2, e2;
    logic [2:0] pc2, fc2, cc2, ic2, ff2;

    logic       en3;
    logic [3:0] a3;
    logic       tog3, p3, f3, e3;
    logic [15:0] pc3, fc3, cc3, ic3, ff3;

    int n_checks = 0;
    int n_errors = 0;

    chronologic u0 (.clk(clk), .rst(rst), .en(en0), .clr(clr0), .a(a0),
        .toggled(tog0), .pass(p0), .fail(f0), .err_sticky(e0), .pass_cnt(pc0), .fail_cnt(fc0),
        .cycle_cnt(cc0), .idle_cnt(ic0), .first_fail_cyc(ff0));

    chronologic #(.MAX_IDLE(2)) u1 (.clk(clk), .rst(rst), .en(en1), .clr(1'b0), .a(a1),
        .toggled(tog1), .pass(p1), .fail(f1), .err_sticky(e1), .pass_cnt(pc1), .fail_cnt(fc1),
        .cycle_cnt(cc1), .idle_cnt(ic1), .first_fail_cyc(ff1));

    chronologic #(.CNT_W(3)) u2 (.clk(clk), .rst(rst), .en(en2), .clr(1'b0), .a(a2),
        .toggled(tog2), .pass(p2), .fail(f2), .err_sticky(e2), .pass_cnt(pc2), .fail_cnt(fc2),
        .cycle_cnt(cc2), .idle_cnt(ic2), .first_fail_cyc(ff2));

    chronologic #(.WIDTH(4)) u3 (.clk(clk), .rst(rst), .en(en3), .clr(1'b0), .a(a3),
        .toggled(tog3), .pass(p3), .fail(f3), .err_sticky(e3), .pass_cnt(pc3), .fail_cnt(fc3),
        .cycle_cnt(cc3), .idle_cnt(ic3), .first_fail_cyc(ff3));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic en, clr, a;
        logic tog, p, f, e;
        int   pc, fc, cc, ic, ff;
    } vec_t;

    vec_t tbl[15];

    function automatic vec_t mk(input logic en, input logic clr, input logic a,
                                input logic tog, input logic p, input logic f, input logic e,
                                input int pc, input int fc, input int cc, input int ic, input int ff);
        vec_t v;
        v.en = en; v.clr = clr; v.a = a;
        v.tog = tog; v.p = p; v.f = f; v.e = e;
        v.pc = pc; v.fc = fc; v.cc = cc; v.ic = ic; v.ff = ff;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_u0(input string tag, input logic tog, input logic p, input logic f, input logic e,
                          input int pc, input int fc, input int cc, input int ic, input int ff);
        chk({tag, ".toggled"}, 32'(tog0), 32'(tog));
        chk({tag, ".pass"}, 32'(p0), 32'(p));
        chk({tag, ".fail"}, 32'(f0), 32'(f));
        chk({tag, ".err_sticky"}, 32'(e0), 32'(e));
        chk({tag, ".pass_cnt"}, 32'(pc0), pc);
        chk({tag, ".fail_cnt"}, 32'(fc0), fc);
        chk({tag, ".cycle_cnt"}, 32'(cc0), cc);
        chk({tag, ".idle_cnt"}, 32'(ic0), ic);
        chk({tag, ".first_fail_cyc"}, 32'(ff0), ff);
    endtask

    initial begin
        //            en clr a  tog p f e  pc fc cc ic ff
        tbl[0]  = mk(1, 0, 0,  0, 0, 1, 1,  0, 1, 1, 1, 1);
        tbl[1]  = mk(1, 0, 1,  1, 1, 0, 1,  1, 1, 2, 0, 1);
        tbl[2]  = mk(1, 0, 0,  1, 1, 0, 1,  2, 1, 3, 0, 1);
        tbl[3]  = mk(1, 0, 1,  1, 1, 0, 1,  3, 1, 4, 0, 1);
        tbl[4]  = mk(1, 0, 0,  1, 1, 0, 1,  4, 1, 5, 0, 1);
        tbl[5]  = mk(1, 0, 1,  1, 1, 0, 1,  5, 1, 6, 0, 1);
        tbl[6]  = mk(0, 0, 0,  0, 0, 0, 1,  5, 1, 6, 0, 1);
        tbl[7]  = mk(0, 0, 1,  0, 0, 0, 1,  5, 1, 6, 0, 1);
        tbl[8]  = mk(0, 0, 0,  0, 0, 0, 1,  5, 1, 6, 0, 1);
        tbl[9]  = mk(1, 0, 0,  0, 0, 1, 1,  5, 2, 7, 1, 1);
        tbl[10] = mk(1, 1, 1,  0, 0, 0, 0,  0, 0, 0, 0, 0);
        tbl[11] = mk(1, 0, 0,  1, 1, 0, 0,  1, 0, 1, 0, 0);
        tbl[12] = mk(1, 0, 0,  0, 0, 1, 1,  1, 1, 2, 1, 2);
        tbl[13] = mk(1, 0, 0,  0, 0, 1, 1,  1, 2, 3, 2, 2);
        tbl[14] = mk(0, 1, 1,  0, 0, 0, 0,  0, 0, 0, 0, 0);

        rst = 1'b1;
        en0 = 1'b1; clr0 = 1'b0; a0 = 1'b0;
        en1 = 1'b0; a1 = 1'b0;
        en2 = 1'b0; a2 = 1'b0;
        en3 = 1'b0; a3 = 4'h0;

        #2;
        chk_u0("reset", 0, 0, 0, 0, 0, 0, 0, 0, 0);

        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 15; i++) begin
            en0 = tbl[i].en; clr0 = tbl[i].clr; a0 = tbl[i].a;
            @(posedge clk);
            #1;
            chk_u0($sformatf("vec%0d", i), tbl[i].tog, tbl[i].p, tbl[i].f, tbl[i].e,
                   tbl[i].pc, tbl[i].fc, tbl[i].cc, tbl[i].ic, tbl[i].ff);
            chk($sformatf("vec%0d.exclusive", i), 32'(p0 & f0), 32'd0);
            @(negedge clk);
        end

        // prev holds 1 after the last vector; a=0 gives a PASS, then reset lands between edges
        en0 = 1'b1; clr0 = 1'b0; a0 = 1'b0;
        @(posedge clk);
        #1;
        chk("async.pass_before", 32'(p0), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk_u0("async", 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b0;
        en0 = 1'b0;

        en1 = 1'b1; en2 = 1'b1; en3 = 1'b1;
        for (int k = 0; k < 9; k++) begin
            a1 = (k < 5) ? 1'b1 : 1'b0;
            a2 = (k % 2 == 0) ? 1'b1 : 1'b0;
            a3 = (k == 0) ? 4'h0 : 4'h1;
            @(posedge clk);
            #1;
            case (k)
                0: begin
                    chk("idle.k0.pass", 32'(p1), 32'd1);
                    chk("idle.k0.idle", 32'(ic1), 32'd0);
                    chk("w4.k0.fail", 32'(f3), 32'd1);
                end
                1: begin
                    chk("idle.k1.strobe", 32'({p1, f1}), 32'd0);
                    chk("idle.k1.idle", 32'(ic1), 32'd1);
                    chk("w4.k1.pass", 32'(p3), 32'd1);
                    chk("w4.k1.toggled", 32'(tog3), 32'd1);
                end
                2: begin
                    chk("idle.k2.strobe", 32'({p1, f1}), 32'd0);
                    chk("idle.k2.idle", 32'(ic1), 32'd2);
                end
                3: begin
                    chk("idle.k3.fail", 32'(f1), 32'd1);
                    chk("idle.k3.fail_cnt", 32'(fc1), 32'd1);
                    chk("idle.k3.first_fail", 32'(ff1), 32'd4);
                end
                4: begin
                    chk("idle.k4.fail", 32'(f1), 32'd1);
                    chk("idle.k4.fail_cnt", 32'(fc1), 32'd2);
                end
                5: begin
                    chk("idle.k5.pass", 32'(p1), 32'd1);
                    chk("idle.k5.idle", 32'(ic1), 32'd0);
                    chk("idle.k5.fail_cnt", 32'(fc1), 32'd2);
                end
                6: chk("sat.k6.pass_cnt", 32'(pc2), 32'd7);
                default: ;
            endcase
            chk($sformatf("sat.k%0d.pass", k), 32'(p2), 32'd1);
            if (k == 1) en3 = 1'b0;
            @(negedge clk);
        end
        chk("sat.pass_cnt", 32'(pc2), 32'd7);
        chk("sat.cycle_cnt", 32'(cc2), 32'd7);
        chk("sat.fail_cnt", 32'(fc2), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
